// File: rtl/clk_div_ctrl_if.sv
// Configuration port of the clock-divider controller: a half-period offered
// on a valid/ready handshake.
interface clk_div_ctrl_if #(
   parameter int unsigned NBITS = 32
);
   logic             cfg_valid;
   logic [NBITS-1:0] cfg_div;
   logic             cfg_ready;

   modport master (output cfg_valid, output cfg_div, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider: produces clk_out/tick from clk_in and
// sequences start, stop and ratio changes only at output-period boundaries.
module clk_div_ctrl #(
   parameter int unsigned NBITS           = 32,
   parameter int unsigned FREQUENCY       = 1,
   parameter int unsigned REFERENCE_CLOCK = 20
) (
   input  logic           clk_in,
   input  logic           reset,
   input  logic           enable,
   clk_div_ctrl_if.slave  cfg,
   output logic           clk_out,
   output logic           tick,
   output logic           running
);

   localparam int unsigned      DEF_RAW      = REFERENCE_CLOCK / (2 * FREQUENCY);
   localparam logic [NBITS-1:0] DEFAULT_HALF = (DEF_RAW == 0) ? NBITS'(1) : NBITS'(DEF_RAW);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [NBITS-1:0] cnt_q, cnt_d;
   logic [NBITS-1:0] active_half_q, active_half_d;
   logic [NBITS-1:0] pending_half_q, pending_half_d;
   logic             pending_q, pending_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             running_q, running_d;
   logic             cfg_ready_q, cfg_ready_d;

   logic             accept;
   logic             boundary;
   logic [NBITS-1:0] cfg_val;
   logic [NBITS-1:0] stop_half;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      active_half_d  = active_half_q;
      pending_half_d = pending_half_q;
      pending_d      = pending_q;
      clk_out_d      = clk_out_q;
      tick_d         = 1'b0;

      accept    = cfg.cfg_valid && !pending_q;
      cfg_val   = (cfg.cfg_div == '0) ? NBITS'(1) : cfg.cfg_div;
      boundary  = (cnt_q == active_half_q - NBITS'(1));
      // Entering STOP flushes whatever ratio is waiting, including one arriving now
      stop_half = accept ? cfg_val : (pending_q ? pending_half_q : active_half_q);

      case (state_q)
         ST_STOP: begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            if (accept) begin
               active_half_d = cfg_val;
            end
            if (enable) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            if ((state_q == ST_RUN) && !enable && !clk_out_q) begin
               state_d       = ST_STOP;
               cnt_d         = '0;
               active_half_d = stop_half;
               pending_d     = 1'b0;
            end else begin
               // Low enable here implies clk_out is high: finish the high phase
               state_d = enable ? ST_RUN : ST_DRAIN;
               if (accept) begin
                  pending_half_d = cfg_val;
                  pending_d      = 1'b1;
               end
               if (boundary) begin
                  cnt_d     = '0;
                  clk_out_d = !clk_out_q;
                  if (!clk_out_q) begin
                     tick_d = 1'b1;
                     if (pending_q) begin
                        active_half_d = pending_half_q;
                        pending_d     = 1'b0;
                     end
                  end else if (!enable) begin
                     state_d       = ST_STOP;
                     active_half_d = stop_half;
                     pending_d     = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + NBITS'(1);
               end
            end
         end
      endcase

      running_d   = (state_d != ST_STOP);
      cfg_ready_d = !pending_d;
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         state_q       <= ST_STOP;
         cnt_q         <= '0;
         active_half_q <= DEFAULT_HALF;
         pending_q     <= 1'b0;
         clk_out_q     <= 1'b0;
         tick_q        <= 1'b0;
         running_q     <= 1'b0;
         cfg_ready_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         active_half_q <= active_half_d;
         pending_q     <= pending_d;
         clk_out_q     <= clk_out_d;
         tick_q        <= tick_d;
         running_q     <= running_d;
         cfg_ready_q   <= cfg_ready_d;
      end
   end

   // Staged ratio is only meaningful while pending_q is set
   always_ff @(posedge clk_in) begin
      pending_half_q <= pending_half_d;
   end

   assign clk_out       = clk_out_q;
   assign tick          = tick_q;
   assign running       = running_q;
   assign cfg.cfg_ready = cfg_ready_q;

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable, glitch-free clock-divider controller. It generates a divided output clock from the reference clock and sequences run, stop and ratio changes so that `clk_out` never produces a runt pulse. Ratio updates arrive over a valid/ready configuration port and are applied only at output-period boundaries. The block sits between the system configuration logic and every consumer of the divided clock/tick.

## Interface

Parameters:

- `NBITS`, 32: width of the half-period counter and of `cfg_div`.
- `FREQUENCY`, 1: default output frequency, in the same units as `REFERENCE_CLOCK`.
- `REFERENCE_CLOCK`, 20: reference clock frequency. The default half-period is `DEFAULT_HALF = REFERENCE_CLOCK/(2*FREQUENCY)`, which is 10 with the defaults. If this evaluates to 0, it is clamped to 1.

Ports (clock and reset first):

- `clk_in`, in, 1: reference clock. There is a single clock domain and everything is on the rising edge.
- `reset`, in, 1: **synchronous, active-low** reset.
- `enable`, in, 1: run request. 1 means run; 0 means stop at the next safe point.
- `cfg_valid`, in, 1: a new half-period is offered on `cfg_div`.
- `cfg_div`, in, NBITS: requested half-period in `clk_in` cycles. The value 0 is treated as 1.
- `cfg_ready`, out, 1: the controller can accept a configuration this cycle.
- `clk_out`, out, 1: divided clock, registered, 50 % duty cycle, period = 2·half.
- `tick`, out, 1: one-cycle pulse, high during the first `clk_in` cycle in which `clk_out` is high.
- `running`, out, 1: high while the state is not STOP.

## Operation

- **Internal registers:** `active_half`, `pending_half`, `pending` flag, `cnt` (NBITS), and `state`.
- **States:**
  - STOP: `clk_out` is held at 0 and `cnt` is held at 0.
  - RUN: the output toggles.
  - DRAIN: stop has been requested and the controller is finishing the current high phase.
- **Reset (reset==0 at a clock edge):**
  - `state`=STOP, `cnt`=0, `active_half`=DEFAULT_HALF, `pending`=0.
  - Outputs: `clk_out`=0, `tick`=0, `running`=0, `cfg_ready`=1.
  - Reset overrides every other input in that cycle, including an in-flight handshake, which is discarded.
- **Counting (RUN and DRAIN):**
  - Each cycle, `cnt` increments.
  - When `cnt == active_half-1`, `cnt` goes to 0 and `clk_out` toggles. This is a "boundary".
  - A 0→1 toggle is a "rising boundary", and `tick` is registered high alongside it.
- **STOP→RUN:** `enable`==1 is sampled in STOP. `cnt` starts from 0 and `clk_out` stays low for exactly `active_half` cycles before its first rise.
- **RUN→STOP or DRAIN:** `enable`==0 is sampled in RUN.
  - If `clk_out`==0, go directly to STOP. `cnt` clears and the low level holds.
  - If `clk_out`==1, go to DRAIN and keep counting. At the falling boundary, go to STOP.
- **DRAIN→RUN:** `enable`==1 is sampled in DRAIN. Return to RUN with no disturbance to `cnt` or `clk_out`.
- **Configuration handshake:**
  - A transfer occurs when `cfg_valid && cfg_ready`. `cfg_ready` = !`pending`.
  - In STOP: `active_half` is loaded directly at that edge and `pending` stays 0.
  - In RUN or DRAIN: the value goes to `pending_half` and `pending` is set to 1, so `cfg_ready` drops on the next cycle.
- **Applying a pending value:**
  - It is applied at the next rising boundary: `active_half` ← `pending_half` and `pending` ← 0.
  - It is also applied on entry to STOP, whichever comes first.
- **Transfer coinciding with a boundary:** if a transfer lands in the same cycle as a rising boundary, the new value is stored as pending and applies at the following rising boundary. It never applies mid-period.
- **Clamp:** a `cfg_div` of 0 is stored as 1. Values are unsigned and compared at full NBITS, with no wrap.

## Timing

- `clk_out`, `tick`, `cfg_ready` and `running` are all registered, with no combinational paths from any input.
- Reset release to the first `clk_out` rise takes `active_half` cycles after `enable` is first sampled high.
- With half=H, `clk_out` is high for H cycles and low for H cycles. `tick` has period 2H.
- Ratio-change latency is at most 2·H_old + 1 cycles from acceptance to the first period at H_new.
- Stop latency is at most H cycles (DRAIN). `running` falls in the same cycle that `clk_out` falls when leaving DRAIN.
- For H=1, `clk_out` toggles every cycle and `tick` is high every other cycle.

## Test plan

- **Defaults:** release reset and hold `enable`=1. Require the first `clk_out` rise 10 cycles after the enable sample, then a period of 20 cycles, a 10/10 duty cycle, and `tick` pulses exactly 20 cycles apart.
- **Reconfigure mid-high:** with H=10, send `cfg_div`=3 at `cnt`=4 of a high phase. Require that:
  - `cfg_ready` goes low for the following cycles;
  - the current period completes at 10/10;
  - the period after the next rising boundary is 3/3;
  - `cfg_ready` returns to 1.
- **Stop while high:** drop `enable` at high-phase `cnt`=2 with H=10. Require 7 more high cycles, then `clk_out`=0, `running`=0, and no further toggles. Re-enabling must give 10 low cycles before the next rise.
- **Zero ratio and STOP load:** in STOP, write `cfg_div`=0, then enable. Require a half-period of 1, i.e. `clk_out` alternating every cycle and `tick` every 2 cycles.
- **Simultaneous events:** send `cfg_div`=5 in the exact cycle of a rising boundary. Require that it is applied at the next rising boundary, not the current one. Then drop `enable` while `pending`=1 and `clk_out`=0. Require that STOP is entered and `active_half`=5.
- **Reset mid-run:** assert `reset`=0 for 1 cycle while `clk_out`=1 and `pending`=1. Require `clk_out`=0, `tick`=0, `running`=0, `cfg_ready`=1 on the next edge, and a half-period back at 10.
